// File: rtl/func_pkg.sv
// Shared function-field encodings for the HI/LO unit operations.
package func_pkg;

    typedef enum logic [5:0] {
        FUNC_MTHI  = 6'h11,
        FUNC_MTLO  = 6'h13,
        FUNC_MULT  = 6'h18,
        FUNC_MULTU = 6'h19,
        FUNC_DIV   = 6'h1A,
        FUNC_DIVU  = 6'h1B
    } Func_t;

endpackage

// File: rtl/muldiv_pkg.sv
// Shared multiply/divide state encoding, default latencies and a small helper.
package muldiv_pkg;

    localparam int DEF_DIV_CYCLES = 32;
    localparam int DEF_MUL_LAT    = 3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } MdState_t;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [32:0] rem_shift;
    logic        fits;
    logic [31:0] rem_sub;

    // The dividend is shifted out of the quotient register MSB-first while
    // quotient bits are shifted in at the bottom.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        fits      = (rem_shift >= {1'b0, dsr_q});
        rem_sub   = rem_shift[31:0] - dsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CNT_W'(DIV_CYCLES - 1);
        end else if (step) begin
            rem_q <= fits ? rem_sub : rem_shift[31:0];
            quo_q <= {quo_q[30:0], fits};
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined multiplier, iterative divider, MTHI/MTLO.
//   state   | meaning
//   MD_IDLE | waiting for a request; MTHI/MTLO complete here
//   MD_MUL  | product travelling down the MUL_LAT-deep pipeline
//   MD_DIV  | divider core producing one quotient bit per cycle
//   MD_FIX  | sign correction of quotient/remainder, HI/LO write
module muldiv_unit
    import func_pkg::*;
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int MUL_LAT    = DEF_MUL_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  Func_t       func,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    MdState_t         state_q;
    logic [MUL_W-1:0] mul_cnt_q;
    logic [63:0]      mul_pipe [MUL_LAT];
    logic             neg_q_q;
    logic             neg_r_q;
    logic             div_zero_q;
    logic [31:0]      rs_saved_q;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        signed_div;
    logic [63:0] mul_prod;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic        core_last;

    always_comb begin
        accept     = start && !flush && (state_q == MD_IDLE);
        is_mul     = (func == FUNC_MULT) || (func == FUNC_MULTU);
        is_div     = (func == FUNC_DIV) || (func == FUNC_DIVU);
        signed_div = (func == FUNC_DIV);
        div_a      = neg_if(signed_div && rs_val[31], rs_val);
        div_b      = neg_if(signed_div && rt_val[31], rt_val);
        // Sign-extending to 64 bits makes the unsigned 64-bit product equal the signed one.
        if (func == FUNC_MULT) begin
            mul_prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        end else begin
            mul_prod = {32'd0, rs_val} * {32'd0, rt_val};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            if (accept && is_mul) begin
                mul_pipe[0] <= mul_prod;
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    muldiv_div_core #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && is_div),
        .step     ((state_q == MD_DIV) && !flush),
        .dividend (div_a),
        .divisor  (div_b),
        .quotient (core_quo),
        .remainder(core_rem),
        .last     (core_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            mul_cnt_q  <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            rs_saved_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        case (func)
                            FUNC_MULT, FUNC_MULTU: begin
                                state_q   <= MD_MUL;
                                busy      <= 1'b1;
                                mul_cnt_q <= MUL_W'(MUL_LAT - 1);
                            end
                            FUNC_DIV, FUNC_DIVU: begin
                                state_q    <= MD_DIV;
                                busy       <= 1'b1;
                                neg_q_q    <= signed_div && (rs_val[31] ^ rt_val[31]);
                                neg_r_q    <= signed_div && rs_val[31];
                                div_zero_q <= (rt_val == '0);
                                rs_saved_q <= rs_val;
                            end
                            FUNC_MTHI: begin
                                hi   <= rs_val;
                                done <= 1'b1;
                            end
                            FUNC_MTLO: begin
                                lo   <= rs_val;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_MUL: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                        busy    <= 1'b0;
                    end else if (mul_cnt_q == '0) begin
                        {hi, lo} <= mul_pipe[MUL_LAT-1];
                        done     <= 1'b1;
                        state_q  <= MD_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 1'b1;
                    end
                end
                MD_DIV: begin
                    if (flush) begin
                        state_q <= MD_IDLE;
                        busy    <= 1'b0;
                    end else if (core_last) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state_q <= MD_IDLE;
                    busy    <= 1'b0;
                    if (!flush) begin
                        // Divide-by-zero bypasses sign fixing so DIV and DIVU report identically.
                        if (div_zero_q) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= rs_saved_q;
                        end else begin
                            lo <= neg_if(neg_q_q, core_quo);
                            hi <= neg_if(neg_r_q, core_rem);
                        end
                        done <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, randomized model check.
module tb_muldiv_unit;
    import func_pkg::*;

    localparam int DIV_CYCLES = 32;
    localparam int MUL_LAT    = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        flush  = 1'b0;
    Func_t       func   = FUNC_MTHI;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        string       name;
        Func_t       f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    muldiv_unit #(
        .DIV_CYCLES(DIV_CYCLES),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .func  (func),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input Func_t f);
        case (f)
            FUNC_MULT, FUNC_MULTU: return MUL_LAT + 1;
            FUNC_DIV, FUNC_DIVU:   return DIV_CYCLES + 2;
            default:               return 1;
        endcase
    endfunction

    function automatic int exp_busy(input Func_t f);
        case (f)
            FUNC_MULT, FUNC_MULTU: return MUL_LAT;
            FUNC_DIV, FUNC_DIVU:   return DIV_CYCLES + 1;
            default:               return 0;
        endcase
    endfunction

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input Func_t f, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ch, input logic [31:0] cl);
        longint sa, sb;
        int     ia, ib, q, r;
        case (f)
            FUNC_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                return 64'(sa * sb);
            end
            FUNC_MULTU: return {32'd0, a} * {32'd0, b};
            FUNC_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = $signed(a);
                ib = $signed(b);
                q  = ia / ib;
                r  = ia % ib;
                return {32'(r), 32'(q)};
            end
            FUNC_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            FUNC_MTHI: return {a, cl};
            default:   return {ch, a};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input string name, input Func_t f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int k  = 0;
        int nb = 0;
        bit got = 0;
        start  = 1'b1;
        func   = f;
        rs_val = a;
        rt_val = b;
        while (!got && k < DIV_CYCLES + 20) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done) got = 1;
            else if (busy) nb++;
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, k, exp_lat(f));
        check({name, " busy_cycles"}, nb, exp_busy(f));
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        Func_t       rf;
        logic [31:0] ra, rb;
        int          nd;

        tbl[0]  = '{"mult_neg",   FUNC_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[1]  = '{"multu",      FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[2]  = '{"div_neg7_2", FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{"divu_100_7", FUNC_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        tbl[4]  = '{"divu_zero",  FUNC_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        tbl[5]  = '{"div_ovf",    FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        tbl[6]  = '{"div_7_neg2", FUNC_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        tbl[7]  = '{"mult_max",   FUNC_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        tbl[8]  = '{"mult_min",   FUNC_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[9]  = '{"mthi",       FUNC_MTHI,  32'h0000_AAAA, 32'd0,         32'h0000_AAAA, 32'h0000_0000};
        tbl[10] = '{"mtlo",       FUNC_MTLO,  32'h0000_5555, 32'd0,         32'h0000_AAAA, 32'h0000_5555};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, issued back-to-back in each done cycle
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el);
        end

        // Flush ten cycles into a DIV: back to idle, no done, HI/LO kept
        @(negedge clk);
        start = 1'b1; func = FUNC_DIV; rs_val = 32'd100; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy_after", 32'(busy), 32'd0);
        count_done(DIV_CYCLES + 5, nd);
        check("flush no_done", nd, 32'd0);
        check("flush hi", hi, 32'h0000_AAAA);
        check("flush lo", lo, 32'h0000_5555);

        // MTHI while a divide is busy is ignored
        start = 1'b1; func = FUNC_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; func = FUNC_MTHI; rs_val = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi_busy hi", hi, 32'h0000_AAAA);
        check("mthi_busy done", 32'(done), 32'd0);
        for (int i = 0; i < DIV_CYCLES + 10 && !done; i++) @(negedge clk);
        check("mthi_busy div_done", 32'(done), 32'd1);
        check("mthi_busy div_hi", hi, 32'd2);
        check("mthi_busy div_lo", lo, 32'd14);
        run_op("mthi_idle", FUNC_MTHI, 32'h1234, 32'd0, 32'h1234, 32'd14);

        // Flush beats a simultaneous start
        @(negedge clk);
        start = 1'b1; func = FUNC_MTLO; rs_val = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_prio done", 32'(done), 32'd0);
        check("flush_prio lo", lo, 32'd14);

        // Unknown function code is ignored
        start = 1'b1; func = Func_t'(6'h20); rs_val = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; func = FUNC_MTHI;
        check("bad_func done", 32'(done), 32'd0);
        check("bad_func busy", 32'(busy), 32'd0);
        check("bad_func hi", hi, 32'h1234);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: rf = FUNC_MULT;
                1: rf = FUNC_MULTU;
                2: rf = FUNC_DIV;
                3: rf = FUNC_DIVU;
                4: rf = FUNC_MTHI;
                default: rf = FUNC_MTLO;
            endcase
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            r = model(rf, ra, rb, m_hi, m_lo);
            run_op("rand", rf, ra, rb, r[63:32], r[31:0]);
        end

        // Reset pulsed mid-MULT clears immediately and no done follows
        @(negedge clk);
        start = 1'b1; func = FUNC_MULT; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid hi", hi, 32'd0);
        check("rst_mid lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(10, nd);
        check("rst_mid no_done", nd, 32'd0);
        check("rst_mid hi_after", hi, 32'd0);
        check("rst_mid lo_after", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
